// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- byte-serial command sequencer in front of the ALU core.
//
// Collects an opcode byte, then operand A, then operand B over a valid/ready
// byte stream. It then issues a single ALU operation and waits for alu_done
// or a timeout. The outcome is held on a valid/ready result port. The ALU
// operands only change while the sequencer is loading, so the core never sees
// a half-loaded command.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   ena            global enable; low freezes all state and blocks handshakes
//   in_valid/in_ready/in_data    byte stream: opcode, A, B
//   alu_op/alu_a/alu_b/alu_start command to the ALU (start is a 1-cycle pulse)
//   alu_done/alu_result/alu_flags completion from the ALU
//   res_valid/res_ready/res_data/res_flags/res_err  result port
module alu_seq_ctrl #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [3:0]        res_flags,
    output logic              res_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_A, S_GET_B, S_ISSUE, S_WAIT, S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_res;
    logic [3:0]        r_flags;
    logic              r_err;
    logic [7:0]        r_cnt;

    logic w_load_state;
    logic w_accept;
    logic w_timeout;

    // in_ready is forced low while reset is held, even though the state
    // register only returns to IDLE on the next edge.
    assign w_load_state = (r_state == S_IDLE) || (r_state == S_GET_A) ||
                          (r_state == S_GET_B);
    assign in_ready     = rst_n & w_load_state;
    assign w_accept     = ena & in_valid & in_ready;
    assign w_timeout    = (r_cnt == 8'(TIMEOUT - 1));

    assign alu_start = rst_n & ena & (r_state == S_ISSUE);
    assign res_valid = rst_n & (r_state == S_HOLD);
    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign res_data  = r_res;
    assign res_flags = r_flags;
    assign res_err   = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_GET_A;
            S_GET_A: if (w_accept) w_next = S_GET_B;
            S_GET_B: if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (alu_done || w_timeout) w_next = S_HOLD;
            S_HOLD:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_flags <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (ena) begin
            r_state <= w_next;
            case (r_state)
                S_IDLE:  if (w_accept) r_op <= in_data[OP_W-1:0];
                S_GET_A: if (w_accept) r_a  <= in_data[DATA_W-1:0];
                S_GET_B: if (w_accept) r_b  <= in_data[DATA_W-1:0];
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    // A completion on the last allowed cycle still wins
                    // over the timeout abort.
                    if (alu_done) begin
                        r_res   <= alu_result;
                        r_flags <= alu_flags;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_res   <= '0;
                        r_flags <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       ena = 1;
    logic       in_valid = 0;
    logic       in_ready;
    logic [7:0] in_data = 0;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic       alu_start;
    logic       alu_done = 0;
    logic [7:0] alu_result = 0;
    logic [3:0] alu_flags = 0;
    logic       res_valid;
    logic       res_ready = 0;
    logic [7:0] res_data;
    logic [3:0] res_flags;
    logic       res_err;

    alu_seq_ctrl #(.DATA_W(8), .OP_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    // expected {err, flags, data}
    logic [12:0] sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1;
        in_data  = d;
        while (!(in_ready && ena) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("send_timeout", 1, 0);
        tick();
        in_valid = 0;
    endtask

    // Called in the ISSUE cycle; raises alu_done dly cycles into WAIT.
    task automatic alu_respond(input int dly, input logic [7:0] r, input logic [3:0] f);
        tick();
        repeat (dly) tick();
        alu_done   = 1;
        alu_result = r;
        alu_flags  = f;
        tick();
        alu_done   = 0;
        alu_result = 0;
        alu_flags  = 0;
    endtask

    task automatic get_result(input string tag);
        int n;
        logic [12:0] e;
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, res_valid, 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"},  res_data,  e[7:0]);
            check({tag, "_flags"}, res_flags, e[11:8]);
            check({tag, "_err"},   res_err,   e[12]);
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        check({tag, "_idle"}, in_ready, 1);
    endtask

    initial begin
        int n;

        // reset state
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_start", alu_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_regs", {alu_op, alu_a, alu_b, res_data, res_flags, res_err}, 0);
        rst_n = 1;
        tick();
        check("idle_in_ready", in_ready, 1);

        // basic ADD, done one cycle after start
        sb.push_back({1'b0, 4'h0, 8'h46});
        send(8'h00); send(8'h12); send(8'h34);
        check("t1_start", alu_start, 1);
        check("t1_cmd", {alu_op, alu_a, alu_b}, {4'h0, 8'h12, 8'h34});
        tick();
        check("t1_start_once", alu_start, 0);
        alu_done = 1; alu_result = 8'h46; alu_flags = 4'h0;
        tick();
        alu_done = 0; alu_result = 0;
        check("t1_valid_at_3", res_valid, 1);
        get_result("t1");

        // backpressure on result port
        sb.push_back({1'b0, 4'h0, 8'h46});
        send(8'h00); send(8'h12); send(8'h34);
        alu_respond(0, 8'h46, 4'h0);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", res_valid, 1);
            check("t2_hold_data", res_data, 8'h46);
            check("t2_hold_in_ready", in_ready, 0);
            tick();
        end
        get_result("t2");

        // timeout: ALU never answers
        sb.push_back({1'b1, 4'h0, 8'h00});
        send(8'h01); send(8'h55); send(8'hAA);
        check("t3_start", alu_start, 1);
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        check("t3_timeout_cycles", n, 16);
        check("t3_cmd_stable", {alu_op, alu_a, alu_b}, {4'h1, 8'h55, 8'hAA});
        get_result("t3");

        // done coincident with last timeout cycle wins
        sb.push_back({1'b0, 4'h5, 8'hA5});
        send(8'h02); send(8'h0F); send(8'hF0);
        alu_respond(14, 8'hA5, 4'h5);
        get_result("t4");

        // ena low while B is offered
        sb.push_back({1'b0, 4'h2, 8'h99});
        send(8'h03); send(8'h21);
        in_valid = 1; in_data = 8'h77; ena = 0;
        repeat (4) tick();
        check("t5_b_blocked", alu_b, 8'hF0);
        check("t5_no_start", alu_start, 0);
        ena = 1;
        tick();
        in_valid = 0;
        check("t5_start", alu_start, 1);
        check("t5_cmd", {alu_op, alu_a, alu_b}, {4'h3, 8'h21, 8'h77});
        alu_respond(0, 8'h99, 4'h2);
        get_result("t5");

        // reset mid-WAIT, then stray done
        send(8'h04); send(8'h01); send(8'h02);
        tick(); tick(); tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        alu_done = 1; alu_result = 8'h3C; alu_flags = 4'hF;
        tick();
        alu_done = 0;
        tick();
        check("t6_no_valid", res_valid, 0);
        check("t6_regs", {alu_op, alu_a, alu_b, res_data, res_flags, res_err}, 0);
        check("t6_idle", in_ready, 1);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
